seq_divider: RTL and testbench

- Multi-cycle unsigned integer divider built on the team's 2's-complement add/subtract datapath.
- Uses non-restoring division: one add-or-subtract of the divisor per cycle, plus one final remainder-correction cycle.
- Serves as the inverse companion to the combinational add/sub ALU and sits beside it in the execute stage.
- Uses a start/busy/done handshake toward the issuing controller.

---
 rtl/seq_divider.sv | 130 +++++++++++++
 tb/tb_seq_divider.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle unsigned non-restoring divider
// Accepts one divide per start in IDLE; WIDTH add/sub steps, then one remainder-fix cycle.
module seq_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             zpend_q, zpend_d;
   logic             done_q, done_d;
   logic             dbz_q, dbz_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;

   logic [WIDTH:0]   dext, shifted, addend, step_sum, fix_r;

   // Subtract is the add of ~D with carry-in 1; the carry-in is the old sign inverted.
   assign dext     = {1'b0, d_q};
   assign shifted  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign addend   = r_q[WIDTH] ? dext : ~dext;
   assign step_sum = shifted + addend + {{WIDTH{1'b0}}, ~r_q[WIDTH]};
   assign fix_r    = r_q[WIDTH] ? (r_q + dext) : r_q;

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         d_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         zpend_q <= 1'b0;
         done_q  <= 1'b0;
         dbz_q   <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         q_q     <= q_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         zpend_q <= zpend_d;
         done_q  <= done_d;
         dbz_q   <= dbz_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
      end
   end

   always_comb begin
      state_d = state_q;
      d_d     = d_q;
      q_d     = q_q;
      r_d     = r_q;
      cnt_d   = cnt_q;
      zpend_d = 1'b0;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE: begin
            // A zero-divisor request completes one edge after accept; Q still holds the dividend.
            if (zpend_q) begin
               done_d = 1'b1;
               dbz_d  = 1'b1;
               quot_d = '1;
               rem_d  = q_q;
            end
            if (start) begin
               d_d   = divisor;
               q_d   = dividend;
               r_d   = '0;
               cnt_d = '0;
               if (!zpend_q) begin
                  dbz_d = 1'b0;
               end
               if (divisor == '0) begin
                  zpend_d = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            r_d   = step_sum;
            q_d   = {q_q[WIDTH-2:0], ~step_sum[WIDTH]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            r_d     = fix_r;
            quot_d  = q_q;
            rem_d   = fix_r[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard bench for seq_divider
// Expected results come from plain / and %; a negedge monitor pops and compares on every done.
module tb_seq_divider;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         z;
      int           acc;
      int           lat;
   } exp_t;

   exp_t         sb[$];
   int           cyc = 0;
   int           n_checks = 0;
   int           n_fail = 0;
   int           n_issued = 0;
   int           n_done = 0;
   int           acc_cyc = 0;
   logic [W-1:0] hold_q = '0;
   logic [W-1:0] hold_r = '0;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pops one expectation; between dones the results must hold.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         hold_q = '0;
         hold_r = '0;
         check("reset_done", {63'd0, done}, 64'd0);
         check("reset_results", {31'd0, quotient, remainder, div_by_zero}, 64'd0);
      end else if (done) begin
         n_done++;
         if (sb.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("quotient", 64'(quotient), 64'(e.q));
            check("remainder", 64'(remainder), 64'(e.r));
            check("div_by_zero", 64'(div_by_zero), 64'(e.z));
            check("latency", 64'(cyc - e.acc), 64'(e.lat));
            hold_q = e.q;
            hold_r = e.r;
         end
      end else begin
         check("hold_results", {32'd0, quotient, remainder}, {32'd0, hold_q, hold_r});
      end
   end

   // Drive start from the bench side of the clock; the next rising edge is the accept edge.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      @(posedge clk);
      #1;
      start   = 1'b0;
      acc_cyc = cyc;
      n_issued++;
      if (b == '0) begin
         e.q = '1;
         e.r = a;
         e.z = 1'b1;
         e.lat = 1;
      end else begin
         e.q = a / b;
         e.r = a % b;
         e.z = 1'b0;
         e.lat = W + 1;
      end
      e.acc = acc_cyc;
      sb.push_back(e);
      check("busy_after_accept", 64'(busy), (b == '0) ? 64'd0 : 64'd1);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) break;
      end
      if (!done) begin
         check("done_timeout", 64'(done), 64'd1);
      end else begin
         check("busy_at_done", 64'(busy), 64'd0);
      end
   endtask

   initial begin
      logic [W-1:0] a, b;
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);

      // Basic and boundary cases.
      issue(16'd100, 16'd7);
      wait_done();
      issue(16'hFFFF, 16'd1);
      wait_done();
      issue(16'hFFFF, 16'hFFFF);
      wait_done();
      issue(16'd5, 16'd9);
      wait_done();

      // Divide by zero: busy must stay low through the done edge.
      issue(16'd1234, 16'd0);
      wait_done();
      check("dbz_busy", 64'(busy), 64'd0);
      @(negedge clk);

      // Starts during an active run are ignored; start on the done cycle is accepted.
      issue(16'd100, 16'd7);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; dividend = 16'd9999; divisor = 16'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      start = 1'b1; dividend = 16'd4321; divisor = 16'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done();
      issue(16'd50, 16'd6);
      wait_done();
      @(negedge clk);

      // Asynchronous reset mid-run: no done, outputs cleared at once.
      issue(16'd1000, 16'd3);
      while (cyc - acc_cyc < 8) @(posedge clk);
      #3;
      rst_n = 1'b0;
      sb.delete();
      n_issued--;
      #1;
      check("midreset_busy", 64'(busy), 64'd0);
      check("midreset_outputs", {31'd0, done, quotient, remainder}, 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue(16'd1000, 16'd3);
      wait_done();

      // Random pairs, issued back-to-back on each done cycle.
      for (int i = 0; i < 1000; i++) begin
         a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
         b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 20)) : W'($urandom);
         if (b == '0) b = 16'd1;
         issue(a, b);
         wait_done();
      end

      repeat (5) @(negedge clk);
      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      check("done_per_start", 64'(n_done), 64'(n_issued));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
